// File: rtl/latch_load_ctrl.sv
// rtl/latch_load_ctrl.sv - flop-driven setup/enable-pulse/hold sequencer feeding a transparent latch bank
//
// Each word accepted over in_valid/in_ready is placed on d, held stable for
// SETUP_CYC cycles, then enable is pulsed high for PULSE_CYC cycles, then d is
// held for HOLD_CYC further cycles before the next word may be accepted.
//
// Ports:
//   clk         single clock, rising edge
//   rst_n       synchronous active-low reset
//   in_valid    upstream word valid
//   in_data     upstream word
//   in_ready    word can be accepted this cycle (IDLE and not in reset)
//   d           registered data bus to latch d inputs
//   enable      registered latch enable
//   busy        controller is not IDLE
//   done        one-cycle pulse in the final HOLD cycle
//   load_count  completed enable pulses, wraps at 16 bits
module latch_load_ctrl #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] d,
  output logic             enable,
  output logic             busy,
  output logic             done,
  output logic [15:0]      load_count
);

  if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
    $error("latch_load_ctrl: SETUP_CYC must be in 1..15");
  end
  if (PULSE_CYC < 1 || PULSE_CYC > 15) begin : g_bad_pulse
    $error("latch_load_ctrl: PULSE_CYC must be in 1..15");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
    $error("latch_load_ctrl: HOLD_CYC must be in 1..15");
  end

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_OPEN,
    S_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             enable_q, enable_d;
  logic [15:0]      load_count_q, load_count_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      d_q          <= '0;
      enable_q     <= 1'b0;
      load_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      d_q          <= d_d;
      enable_q     <= enable_d;
      load_count_q <= load_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    d_d          = d_q;
    enable_d     = enable_q;
    load_count_d = load_count_q;
    case (state_q)
      S_IDLE: begin
        // d is only ever loaded here, so it cannot move under an open latch.
        if (in_valid) begin
          d_d     = in_data;
          cnt_d   = SETUP_LD;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == 4'd0) begin
          cnt_d    = PULSE_LD;
          enable_d = 1'b1;
          state_d  = S_OPEN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_OPEN: begin
        if (cnt_q == 4'd0) begin
          enable_d     = 1'b0;
          load_count_d = load_count_q + 16'd1;
          cnt_d        = HOLD_LD;
          state_d      = S_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        enable_d = 1'b0;
      end
    endcase
  end

  // in_ready is gated by rst_n so nothing is offered as accepted during reset.
  assign in_ready   = (state_q == S_IDLE) & rst_n;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_HOLD) && (cnt_q == 4'd0);
  assign d          = d_q;
  assign enable     = enable_q;
  assign load_count = load_count_q;

endmodule

// File: tb/tb_latch_load_ctrl.sv
// tb/tb_latch_load_ctrl.sv - self-checking bench for latch_load_ctrl
module tb_latch_load_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        vld [2];
  logic [7:0]  din [2];
  logic        rdy [2];
  logic [7:0]  dq  [2];
  logic        en  [2];
  logic        bsy [2];
  logic        dn  [2];
  logic [15:0] lc  [2];

  latch_load_ctrl #(.WIDTH(8), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_data(din[0]),
    .in_ready(rdy[0]), .d(dq[0]), .enable(en[0]), .busy(bsy[0]),
    .done(dn[0]), .load_count(lc[0])
  );

  latch_load_ctrl #(.WIDTH(8), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_data(din[1]),
    .in_ready(rdy[1]), .d(dq[1]), .enable(en[1]), .busy(bsy[1]),
    .done(dn[1]), .load_count(lc[1])
  );

  // Transparent latch on dut1 d[0]/enable.
  logic latch_q;
  always @* if (en[1]) latch_q = dq[1][0];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: each accepted word opens a window of
  // S+P+H cycles indexed by phase (0 = first cycle after the accept edge).
  int          ms [2] = '{1, 3};
  int          mp [2] = '{2, 1};
  int          mh [2] = '{1, 4};
  bit          act [2];
  int          ph [2];
  logic [7:0]  md [2];
  logic [15:0] mcnt [2];
  int          acc_cyc [2];
  int          prev_acc [2];
  int          acc_n [2];
  bit          seen_rst = 1'b0;
  int          cyc = 0;

  initial begin
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0; din[i] = 8'h00; act[i] = 1'b0; ph[i] = 0;
      md[i] = 8'h00; mcnt[i] = 16'h0000; acc_cyc[i] = 0; prev_acc[i] = 0; acc_n[i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        act[i] = 1'b0; md[i] = 8'h00; mcnt[i] = 16'h0000;
      end else if (act[i]) begin
        ph[i]++;
        if (ph[i] == ms[i] + mp[i]) mcnt[i] = mcnt[i] + 16'd1;
        if (ph[i] == ms[i] + mp[i] + mh[i]) act[i] = 1'b0;
      end else if (vld[i]) begin
        act[i] = 1'b1; ph[i] = 0; md[i] = din[i];
        prev_acc[i] = acc_cyc[i]; acc_cyc[i] = cyc; acc_n[i]++;
      end
    end
    if (!rst_n) seen_rst = 1'b1;
    cyc++;
    #1;
    if (seen_rst) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d.in_ready", i), int'(rdy[i]), int'(!act[i] && rst_n));
        chk($sformatf("u%0d.busy", i), int'(bsy[i]), int'(act[i]));
        chk($sformatf("u%0d.enable", i), int'(en[i]),
            int'(act[i] && ph[i] >= ms[i] && ph[i] < ms[i] + mp[i]));
        chk($sformatf("u%0d.done", i), int'(dn[i]),
            int'(act[i] && ph[i] == ms[i] + mp[i] + mh[i] - 1));
        chk($sformatf("u%0d.d", i), int'(dq[i]), int'(md[i]));
        chk($sformatf("u%0d.load_count", i), int'(lc[i]), int'(mcnt[i]));
      end
    end
  end

  // Offer a word on unit i; returns at the negedge of phase 0 after acceptance.
  task automatic send(input int i, input logic [7:0] data, input bit keep);
    int n0;
    bit ok;
    n0 = acc_n[i];
    ok = 1'b0;
    vld[i] = 1'b1;
    din[i] = data;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (acc_n[i] != n0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!keep) vld[i] = 1'b0;
    if (!ok) chk($sformatf("u%0d.accept_timeout", i), 0, 1);
  endtask

  logic [4:0] p_en, p_dn, p_rdy;
  logic [7:0] q_en, q_dn;

  initial begin
    // Reset held with in_valid high.
    vld[0] = 1'b1; din[0] = 8'h77;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.in_ready", int'(rdy[0]), 0);
    chk("rst.d", int'(dq[0]), 0);
    chk("rst.enable", int'(en[0]), 0);
    chk("rst.load_count", int'(lc[0]), 0);
    rst_n = 1'b1;
    vld[0] = 1'b0;
    @(negedge clk);
    chk("release.in_ready", int'(rdy[0]), 1);

    // Single load with defaults: hand-computed phase pattern.
    p_en = 5'b00110; p_dn = 5'b01000; p_rdy = 5'b10000;
    send(0, 8'hA5, 1'b0);
    for (int p = 0; p < 5; p++) begin
      chk($sformatf("single.enable.ph%0d", p), int'(en[0]), int'(p_en[p]));
      chk($sformatf("single.done.ph%0d", p), int'(dn[0]), int'(p_dn[p]));
      chk($sformatf("single.in_ready.ph%0d", p), int'(rdy[0]), int'(p_rdy[p]));
      chk($sformatf("single.d.ph%0d", p), int'(dq[0]), 32'hA5);
      @(negedge clk);
    end
    chk("single.load_count", int'(lc[0]), 1);

    // Back-to-back with in_valid held.
    send(0, 8'hA5, 1'b1);
    send(0, 8'h3C, 1'b0);
    chk("b2b.spacing", acc_cyc[0] - prev_acc[0], 5);
    chk("b2b.d", int'(dq[0]), 32'h3C);

    // Word offered during OPEN is ignored until IDLE.
    repeat (4) @(negedge clk);
    send(0, 8'hA5, 1'b0);
    @(negedge clk);
    vld[0] = 1'b1; din[0] = 8'hFF;
    @(negedge clk);
    chk("ignore.d_held", int'(dq[0]), 32'hA5);
    send(0, 8'hFF, 1'b0);
    chk("ignore.spacing", acc_cyc[0] - prev_acc[0], 5);
    chk("ignore.d_new", int'(dq[0]), 32'hFF);
    chk("ignore.load_count", int'(lc[0]), 4);

    // Parameter sweep unit: setup 3, pulse 1, hold 4.
    q_en = 8'b0000_1000; q_dn = 8'b1000_0000;
    send(1, 8'h01, 1'b0);
    for (int p = 0; p < 8; p++) begin
      chk($sformatf("sweep.enable.ph%0d", p), int'(en[1]), int'(q_en[p]));
      chk($sformatf("sweep.done.ph%0d", p), int'(dn[1]), int'(q_dn[p]));
      @(negedge clk);
    end
    chk("sweep.in_ready", int'(rdy[1]), 1);
    chk("sweep.latch_one", int'(latch_q), 1);
    send(1, 8'h02, 1'b0);
    repeat (8) @(negedge clk);
    chk("sweep.latch_zero", int'(latch_q), 0);
    chk("sweep.load_count", int'(lc[1]), 2);

    // Reset during OPEN.
    repeat (6) @(negedge clk);
    send(0, 8'h5A, 1'b0);
    @(negedge clk);
    chk("midrst.open", int'(en[0]), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst.enable", int'(en[0]), 0);
    chk("midrst.d", int'(dq[0]), 0);
    chk("midrst.done", int'(dn[0]), 0);
    chk("midrst.load_count", int'(lc[0]), 0);
    chk("midrst.in_ready", int'(rdy[0]), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst.no_done", int'(dn[0]), 0);
    chk("midrst.idle", int'(rdy[0]), 1);

    // load_count wrap from 0xFFFF.
    force dut0.load_count_q = 16'hFFFF;
    mcnt[0] = 16'hFFFF;
    @(posedge clk);
    #2;
    release dut0.load_count_q;
    @(negedge clk);
    chk("wrap.preload", int'(lc[0]), 32'hFFFF);
    send(0, 8'hC3, 1'b0);
    repeat (3) @(negedge clk);
    chk("wrap.zero", int'(lc[0]), 0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
